// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: fetch/decode/execute/memory/writeback with a bounded
// memory-ready wait. Define ILLEGAL_TRAP_EN to halt on an illegal decode instead of NOP.
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero_flag,
  input  logic       mem_ready,
  output logic [3:0] alu_sel,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_write,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] state_o
);

  localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,  FETCH  = 4'd1,  DECODE   = 4'd2,  MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,  MEM_WB = 4'd5,  MEM_WR   = 4'd6,  EXEC_R   = 4'd7,
    RTYPE_WB = 4'd8,  EXEC_I = 4'd9,  ADDI_WB  = 4'd10, BRANCH   = 4'd11,
    JUMP     = 4'd12, HALT   = 4'd13
  } state_t;

  state_t           state_q, state_d;
  logic [5:0]       opcode_q, funct_q;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             decode_ok, wait_st, timeout;

  // Every supported funct maps to a non-zero ALU code, so zero doubles as "illegal".
  function automatic logic [3:0] funct_to_sel(input logic [5:0] f);
    case (f)
      6'h20:   return 4'b0001;
      6'h22:   return 4'b0010;
      6'h18:   return 4'b0011;
      6'h1A:   return 4'b0100;
      6'h24:   return 4'b0101;
      6'h25:   return 4'b0110;
      6'h27:   return 4'b0111;
      6'h2A:   return 4'b1000;
      6'h26:   return 4'b1001;
      default: return 4'b0000;
    endcase
  endfunction

  always_comb begin
    case (opcode)
      OP_RTYPE:                         decode_ok = (funct_to_sel(funct) != 4'b0000);
      OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J: decode_ok = 1'b1;
      default:                          decode_ok = 1'b0;
    endcase
  end

  assign wait_st = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
  assign timeout = wait_st && !mem_ready && (wait_q == CNT_W'(MEM_TIMEOUT - 1));
  // Leaving a wait state (or timing out) always restarts the count from zero.
  assign wait_d  = (wait_st && !mem_ready && !timeout) ? wait_q + CNT_W'(1) : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = FETCH;
      FETCH:    if (mem_ready) state_d = DECODE;
      DECODE: begin
        if (!decode_ok) begin
`ifdef ILLEGAL_TRAP_EN
          state_d = HALT;
`else
          state_d = FETCH;
`endif
        end else begin
          case (opcode)
            OP_RTYPE:     state_d = EXEC_R;
            OP_LW, OP_SW: state_d = MEM_ADDR;
            OP_ADDI:      state_d = EXEC_I;
            OP_BEQ:       state_d = BRANCH;
            default:      state_d = JUMP;
          endcase
        end
      end
      MEM_ADDR: state_d = (opcode_q == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD: begin
        if (mem_ready)    state_d = MEM_WB;
        else if (timeout) state_d = FETCH;
      end
      MEM_WB:   state_d = FETCH;
      MEM_WR:   if (mem_ready || timeout) state_d = FETCH;
      EXEC_R:   state_d = RTYPE_WB;
      RTYPE_WB: state_d = FETCH;
      EXEC_I:   state_d = ADDI_WB;
      ADDI_WB:  state_d = FETCH;
      BRANCH:   state_d = FETCH;
      JUMP:     state_d = FETCH;
      HALT:     state_d = HALT;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      opcode_q <= '0;
      funct_q  <= '0;
      wait_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_q == DECODE) begin
        opcode_q <= opcode;
        funct_q  <= funct;
      end
    end
  end

  always_comb begin
    alu_sel    = 4'b0000;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    bus_err    = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_sel   = 4'b0001;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        bus_err   = timeout;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        alu_sel   = 4'b0001;
        illegal   = !decode_ok;
      end
      MEM_ADDR, EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_sel   = 4'b0001;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        bus_err  = timeout;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        bus_err   = timeout;
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_sel   = funct_to_sel(funct_q);
      end
      RTYPE_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      ADDI_WB:  reg_write = 1'b1;
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_sel   = 4'b0010;
        pc_src    = 2'b01;
        pc_write  = zero_flag;
      end
      JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_o = state_q;

endmodule
